// File: rtl/bp_bimodal_table.sv
// Bimodal branch predictor: one saturating counter per PC-indexed entry, with running statistics.
// Optional gshare indexing (global history XORed into the index) is enabled by defining BP_GSHARE_EN.
module bp_bimodal_table #(
  parameter int ENTRIES   = 64,
  parameter int CTR_W     = 2,
  parameter int RESET_CTR = 1,
  parameter int HIST_W    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [5:0]                 OpCode,
  input  logic [31:0]                PC,
  output logic                       Is_Branch,
  output logic                       Branch_likely,
  output logic [$clog2(ENTRIES)-1:0] Pred_Index,
  input  logic                       Update,
  input  logic [$clog2(ENTRIES)-1:0] Update_Index,
  input  logic                       Branch_Actual,
  input  logic                       Mispredict,
  output logic [31:0]                Stat_Branches,
  output logic [31:0]                Stat_Mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(RESET_CTR);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic HIST_OK = (HIST_W >= 1) && (HIST_W <= IDX_W);

  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [31:0]      stat_branches_q;
  logic [31:0]      stat_mispredicts_q;
  logic [IDX_W-1:0] pc_idx;

  assign pc_idx = PC[IDX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  ghr_ext;

  // History only advances at resolve, so it is never speculative.
  if (HIST_W == 1) begin : g_ghr_one
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       ghr <= '0;
      else if (Update) ghr <= Branch_Actual;
    end
  end else begin : g_ghr_shift
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       ghr <= '0;
      else if (Update) ghr <= {ghr[HIST_W-2:0], Branch_Actual};
    end
  end

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_W-1:0] = ghr;
  end

  assign Pred_Index = pc_idx ^ ghr_ext;
`else
  assign Pred_Index = pc_idx;
`endif

  always_comb begin
    case (OpCode)
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: Is_Branch = 1'b1;
      default:                           Is_Branch = 1'b0;
    endcase
  end

  // No bypass: a same-cycle update to the looked-up entry is seen next cycle.
  assign Branch_likely = Is_Branch & ctr[Pred_Index][CTR_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= RST_VAL;
    end else if (Update) begin
      if (Branch_Actual) begin
        if (ctr[Update_Index] != CTR_MAX) ctr[Update_Index] <= ctr[Update_Index] + CTR_ONE;
      end else begin
        if (ctr[Update_Index] != '0) ctr[Update_Index] <= ctr[Update_Index] - CTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (Update) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (Mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign Stat_Branches    = stat_branches_q;
  assign Stat_Mispredicts = stat_mispredicts_q;

  // PC bits outside the index field do not take part in the lookup.
  logic unused_ok;
  assign unused_ok = ^{PC[31:IDX_W+2], PC[1:0], HIST_OK};

endmodule

// File: tb/tb_bp_bimodal_table.sv
// Testbench for bp_bimodal_table: directed scenarios plus random traffic against a behavioural model.
module tb_bp_bimodal_table;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpCode;
  logic [31:0] PC;
  logic        Is_Branch, Branch_likely;
  logic [5:0]  Pred_Index;
  logic        Update;
  logic [5:0]  Update_Index;
  logic        Branch_Actual, Mispredict;
  logic [31:0] Stat_Branches, Stat_Mispredicts;

  bp_bimodal_table dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .PC(PC),
    .Is_Branch(Is_Branch), .Branch_likely(Branch_likely), .Pred_Index(Pred_Index),
    .Update(Update), .Update_Index(Update_Index), .Branch_Actual(Branch_Actual),
    .Mispredict(Mispredict), .Stat_Branches(Stat_Branches), .Stat_Mispredicts(Stat_Mispredicts)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          m_ctr [64];
  int          m_ghr;
  logic [31:0] m_br, m_mp;
  logic [5:0]  ops [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_is_br(input logic [5:0] op);
    return op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'h3F);
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic logic m_pred(input logic [5:0] op, input logic [31:0] pc);
    return m_is_br(op) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_ghr = 0;
    m_br  = '0;
    m_mp  = '0;
  endtask

  task automatic model_update(input int idx, input logic act, input logic misp);
    if (act) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
    else     m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
    m_ghr = ((m_ghr << 1) | int'(act)) & 63;
    m_br  = m_br + 32'd1;
    if (misp) m_mp = m_mp + 32'd1;
  endtask

  task automatic check_outputs(input logic [5:0] op, input logic [31:0] pc);
    chk("is_branch", 32'(Is_Branch), 32'(m_is_br(op)));
    chk("branch_likely", 32'(Branch_likely), 32'(m_pred(op, pc)));
    chk("pred_index", 32'(Pred_Index), 32'(m_idx(pc)));
    chk("stat_branches", Stat_Branches, m_br);
    chk("stat_mispredicts", Stat_Mispredicts, m_mp);
  endtask

  // One cycle: drive at negedge, check combinational lookup, then clock the update.
  task automatic step(input logic [5:0] op, input logic [31:0] pc, input logic upd,
                      input logic [5:0] uidx, input logic act, input logic misp);
    @(negedge clk);
    OpCode = op; PC = pc; Update = upd; Update_Index = uidx;
    Branch_Actual = act; Mispredict = misp;
    #1;
    check_outputs(op, pc);
    @(posedge clk);
    if (upd) model_update(int'(uidx), act, misp);
  endtask

  initial begin
    ops = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h23, 6'h00, 6'h2b};
    reset = 1'b1; OpCode = 6'h04; PC = 32'h0; Update = 1'b0; Update_Index = '0;
    Branch_Actual = 1'b0; Mispredict = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_outputs(6'h04, 32'h0);
    chk("reset_likely", 32'(Branch_likely), 32'd0);
    reset = 1'b0;

    // Cleared state lookups.
    step(6'h04, 32'h1234_5678, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("op04_branch", 32'(Is_Branch), 32'd1);
    step(6'h23, 32'h0000_0014, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("op23_branch", 32'(Is_Branch), 32'd0);

    // Two taken pulses on index 5 with same-cycle lookup at PC 0x14.
    step(6'h04, 32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
    chk("idx5_first_pulse", 32'(Branch_likely), 32'd0);
    step(6'h04, 32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
    chk("idx5_second_pulse", 32'(Branch_likely), 32'd1);
    step(6'h04, 32'h18, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("idx6_untouched", 32'(Branch_likely), 32'd0);

    // Saturation on index 3, then repeated not-taken on index 7.
    repeat (5) step(6'h05, 32'h0C, 1'b1, 6'd3, 1'b1, 1'b0);
    step(6'h05, 32'h0C, 1'b1, 6'd3, 1'b0, 1'b0);
    step(6'h05, 32'h0C, 1'b1, 6'd3, 1'b0, 1'b0);
    chk("idx3_after_one_nt", 32'(Branch_likely), 32'd1);
    step(6'h05, 32'h0C, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("idx3_after_two_nt", 32'(Branch_likely), 32'd0);
    repeat (5) step(6'h06, 32'h1C, 1'b1, 6'd7, 1'b0, 1'b0);
    step(6'h06, 32'h1C, 1'b1, 6'd7, 1'b1, 1'b0);
    step(6'h06, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("idx7_floor_then_taken", 32'(Branch_likely), 32'd0);

    // Same-cycle hazard: bring index 5 back to 01, then update while looking up.
    repeat (2) step(6'h04, 32'h20, 1'b1, 6'd5, 1'b0, 1'b0);
    step(6'h04, 32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
    chk("hazard_same_cycle", 32'(Branch_likely), 32'd0);
    step(6'h04, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("hazard_next_cycle", 32'(Branch_likely), 32'd1);

    // Asynchronous reset mid-sequence with a concurrent Update that must be dropped.
    @(negedge clk);
    reset = 1'b1; Update = 1'b1; Update_Index = 6'd5; Branch_Actual = 1'b1; Mispredict = 1'b1;
    OpCode = 6'h04; PC = 32'h14;
    #1;
    model_reset();
    check_outputs(6'h04, 32'h14);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; Update = 1'b0;
    step(6'h04, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0);

    // Ten updates, three flagged as mispredicts.
    for (int i = 0; i < 10; i++)
      step(6'h01, 32'(i * 4), 1'b1, 6'(i), 1'(i % 2), 1'(i < 3));
    step(6'h00, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("stats_ten_branches", Stat_Branches, 32'd10);
    chk("stats_three_misp", Stat_Mispredicts, 32'd3);

    // Wrap both statistics counters.
    @(negedge clk);
    force dut.stat_branches_q = 32'hFFFF_FFFF;
    force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_branches_q;
    release dut.stat_mispredicts_q;
    m_br = 32'hFFFF_FFFF;
    m_mp = 32'hFFFF_FFFF;
    step(6'h07, 32'h40, 1'b1, 6'd16, 1'b1, 1'b1);
    step(6'h07, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("stats_wrap_branches", Stat_Branches, 32'd0);
    chk("stats_wrap_misp", Stat_Mispredicts, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      logic [5:0]  rop;
      logic [5:0]  ridx;
      rpc  = $urandom;
      rop  = ops[$urandom_range(7)];
      ridx = ($urandom_range(3) == 0) ? 6'($urandom) : 6'(m_idx(rpc));
      step(rop, rpc, 1'($urandom_range(1)), ridx, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
